// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-side memory responder.
//   - MMIO window base (upper address half) and register offsets.
//   - STATUS register bit positions.
package dmem_pkg;

  // Upper 16 address bits that select the MMIO window.
  localparam logic [15:0] MMIO_BASE  = 16'hFFFF;

  // Register offsets within the MMIO window (address[15:0]).
  localparam logic [15:0] OFF_TXDATA = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0004;
  localparam logic [15:0] OFF_CYCLE  = 16'h0008;

  // STATUS register layout.
  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_ERR     = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_W   = 5;

  // Assemble the STATUS read word.
  function automatic logic [31:0] pack_status(input logic             full,
                                              input logic             empty,
                                              input logic             ovf,
                                              input logic             err,
                                              input logic [ST_CNT_W-1:0] count);
    logic [31:0] s;
    s                                   = '0;
    s[ST_FULL]                          = full;
    s[ST_EMPTY]                         = empty;
    s[ST_OVF]                           = ovf;
    s[ST_ERR]                           = err;
    s[ST_CNT_LSB +: ST_CNT_W]           = count;
    return s;
  endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo: small byte FIFO feeding the transmit drain port.
//   clk          clock
//   reset        synchronous active-high reset; empties the FIFO
//   push_i       request to enqueue push_data_i
//   push_data_i  byte to enqueue
//   pop_i        request to dequeue the head (ignored when empty)
//   head_o       head byte; 0 when empty
//   full_o       FIFO holds FIFO_DEPTH entries
//   empty_o      FIFO holds no entries
//   count_o      number of entries held (0..FIFO_DEPTH)
// A push while full is accepted only when a pop happens in the same cycle.
module tx_byte_fifo #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic [7:0]                    push_data_i,
  input  logic                          pop_i,
  output logic [7:0]                    head_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            pop_ok, push_ok;

  assign full_o  = (count_q == CntW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  // When full, the slot being written is the head being popped this cycle,
  // so the new byte lands behind the remaining entries.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; head_o is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-side memory for the single-cycle RISC-V core.
// Word RAM plus an MMIO window (TX byte FIFO, STATUS, CYCLE counter).
//   clk       clock
//   reset     synchronous active-high reset
//   we        store strobe from the core
//   address   byte address from the core
//   wdata     store data
//   rdata     load data, combinational
//   tx_data   byte at the TX FIFO head
//   tx_valid  TX FIFO non-empty
//   tx_ready  consumer accepts the head byte this cycle
//   err       sticky access-error flag (misaligned / out-of-range store)
// Build option: define DMEM_CYCLE_COUNTER_EN to build the 32-bit cycle
// counter behind CYCLE; otherwise CYCLE reads 0.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] RamBytes = 33'(4 * DEPTH_WORDS);

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic             mmio_sel;
  logic             ram_sel;
  logic             misaligned;
  logic             access_err;
  logic [15:0]      mmio_off;
  logic [AddrW-1:0] ram_idx;

  assign mmio_sel   = (address[31:16] == MMIO_BASE);
  assign ram_sel    = !mmio_sel && ({1'b0, address} < RamBytes);
  assign misaligned = (address[1:0] != 2'b00);
  assign access_err = misaligned || (!mmio_sel && !ram_sel);
  assign mmio_off   = address[15:0];
  assign ram_idx    = address[AddrW+1:2];

  logic ram_we;
  logic txdata_wr;
  logic status_wr;

  assign ram_we    = we && ram_sel && !misaligned;
  assign txdata_wr = we && mmio_sel && !misaligned && (mmio_off == OFF_TXDATA);
  assign status_wr = we && mmio_sel && !misaligned && (mmio_off == OFF_STATUS);

  // ---------------------------------------------------------------------
  // Data RAM (not reset)
  // ---------------------------------------------------------------------
  logic [31:0] ram_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= wdata;
    end
  end

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  logic            fifo_full;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            fifo_pop;

  assign tx_valid = !fifo_empty;
  assign fifo_pop = tx_valid && tx_ready;

  tx_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (txdata_wr),
    .push_data_i (wdata[7:0]),
    .pop_i       (fifo_pop),
    .head_o      (tx_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // ---------------------------------------------------------------------
  // Sticky flags
  // ---------------------------------------------------------------------
  logic ovf_q, ovf_d;
  logic err_q, err_d;
  logic ovf_set;

  // A byte is dropped only if the FIFO is full and no pop frees a slot.
  assign ovf_set = txdata_wr && fifo_full && !fifo_pop;

  always_comb begin
    ovf_d = ovf_q;
    if (status_wr && wdata[ST_OVF]) begin
      ovf_d = 1'b0;
    end
    // Set has priority over a same-cycle clear.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
    err_d = err_q || (we && access_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

  // ---------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------
  logic [31:0] cycle_val;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;

  // Held at 0 during reset so the first cycle after release reads 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  // ---------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------
  logic [31:0] status_word;

  assign status_word = pack_status(fifo_full, fifo_empty, ovf_q, err_q,
                                   ST_CNT_W'(fifo_count));

  always_comb begin
    rdata = '0;
    if (!access_err) begin
      if (mmio_sel) begin
        case (mmio_off)
          OFF_STATUS: rdata = status_word;
          OFF_CYCLE:  rdata = cycle_val;
          default:    rdata = '0;
        endcase
      end else begin
        rdata = ram_q[ram_idx];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder
// with DEPTH_WORDS=1024 and FIFO_DEPTH=8. Honours DMEM_CYCLE_COUNTER_EN.
module tb_data_mem_responder;

  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC = 32'hFFFF_0008;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(
    .DEPTH_WORDS (1024),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .address  (address),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a load address and check the combinational read data.
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    address = addr;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    we      = 1'b1;
    address = addr;
    wdata   = data;
    tick();
    we      = 1'b0;
  endtask

  logic [31:0] exp_cyc5;

  initial begin
`ifdef DMEM_CYCLE_COUNTER_EN
    exp_cyc5 = 32'd5;
`else
    exp_cyc5 = 32'd0;
`endif
    reset    = 1'b1;
    we       = 1'b0;
    address  = A_ST;
    wdata    = '0;
    tx_ready = 1'b0;
    tick();
    tick();
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    reset = 1'b0;

    // Cycle counter: 0 in first cycle after release, 5 five edges later.
    rd("cycle_first", A_CYC, 32'd0);
    repeat (5) tick();
    rd("cycle_plus5", A_CYC, exp_cyc5);
    rd("status_idle", A_ST, 32'h0000_0002);
    store(A_CYC, 32'h1234_5678);
    chk("cycle_wr_no_err", {31'b0, err}, 32'd0);

    // RAM store/load.
    store(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_rd_10", 32'h0000_0010, 32'hDEAD_BEEF);
    chk("ram_no_err", {31'b0, err}, 32'd0);
    store(32'h0000_0FFC, 32'h1234_5678);
    rd("ram_rd_top", 32'h0000_0FFC, 32'h1234_5678);
    rd("oor_rd_zero", 32'h0000_1000, 32'd0);
    chk("oor_rd_no_err", {31'b0, err}, 32'd0);
    store(32'hFFFF_000C, 32'hFFFF_FFFF);
    chk("mmio_other_no_err", {31'b0, err}, 32'd0);

    // Misaligned store sets err and does not modify RAM.
    store(32'h0000_0012, 32'h1111_1111);
    chk("mis_err", {31'b0, err}, 32'd1);
    rd("mis_status", A_ST, 32'h0000_000A);
    rd("mis_word_kept", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("mis_rd_zero", 32'h0000_0012, 32'd0);

    // First TXDATA push: visible next cycle.
    store(A_TX, 32'h0000_0041);
    chk("push1_valid", {31'b0, tx_valid}, 32'd1);
    chk("push1_head", {24'b0, tx_data}, 32'h41);
    rd("push1_status", A_ST, 32'h0000_0018);

    // Eight more pushes; the last overflows.
    for (int i = 1; i < 9; i++) begin
      store(A_TX, 32'h41 + i);
    end
    rd("ovf_status", A_ST, 32'h0000_008D);

    // Drain 0x41..0x48.
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_a_%0d", i), {24'b0, tx_data}, 32'h41 + i);
      tick();
    end
    chk("drain_a_empty", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    rd("drain_a_status", A_ST, 32'h0000_000E);
    store(A_ST, 32'h0000_0004);
    rd("ovf_clear", A_ST, 32'h0000_000A);

    // Fill to full, then push while popping.
    for (int i = 0; i < 8; i++) begin
      store(A_TX, 32'h50 + i);
    end
    rd("full_status", A_ST, 32'h0000_0089);
    tx_ready = 1'b1;
    #1;
    chk("full_head", {24'b0, tx_data}, 32'h50);
    store(A_TX, 32'h0000_005A);
    tx_ready = 1'b0;
    rd("push_pop_status", A_ST, 32'h0000_0089);
    tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("drain_b_%0d", i), {24'b0, tx_data}, 32'h51 + i);
      tick();
    end
    chk("drain_b_last", {24'b0, tx_data}, 32'h5A);
    tick();
    chk("drain_b_empty", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Reset mid-drain with bytes queued.
    store(A_TX, 32'h61);
    store(A_TX, 32'h62);
    store(A_TX, 32'h63);
    tx_ready = 1'b1;
    tick();
    chk("mid_drain_head", {24'b0, tx_data}, 32'h62);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst2_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst2_err", {31'b0, err}, 32'd0);
    rd("rst2_status", A_ST, 32'h0000_0002);
    rd("rst2_cycle", A_CYC, 32'd0);
    rd("rst2_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
    tx_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-side memory responder for the single-cycle RISC-V core: services the core's `WE` / `address_to_mem` / `data_to_mem` / `data_from_mem` port.
- Contains a word-organised data RAM.
- Provides a small memory-mapped I/O window: a transmit byte FIFO with a valid/ready drain port, a status register and a cycle counter.
- Reads are combinational, because the core has no stall; all state changes on the rising clock edge.

## Interface
- `DEPTH_WORDS`, 1024 — RAM size in 32-bit words; must be a power of two.
- `FIFO_DEPTH`, 8 — TX FIFO entries; power of two, 2..16.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `we`  in  1  store strobe from the core (`WE`).
- `address`  in  32  byte address from the core (`address_to_mem`).
- `wdata`  in  32  store data (`data_to_mem`).
- `rdata`  out  32  load data (`data_from_mem`); combinational.
- `tx_data`  out  8  byte at the FIFO head.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts the head byte this cycle.
- `err`  out  1  sticky access-error flag.

## Operation
Address decode:
- `address[31:16] == 16'hFFFF` selects MMIO.
- Any other address with `address < 4*DEPTH_WORDS` selects RAM.
- Everything else is out-of-range.
- An access is misaligned if `address[1:0] != 0`.

RAM:
- Index is `address[log2(DEPTH_WORDS)+1:2]`.
- `rdata` shows the word at the index combinationally.
- When `we` is high, the word at the index is written with `wdata` at the clock edge.
- Reset does not clear RAM contents.

Errors (misaligned or out-of-range, in any region):
- Writes are ignored and `rdata` = 0.
- If the access is a write, `err` sets at the next edge. Reads never set `err`.
- `err` clears only on reset.

MMIO registers:
- `0xFFFF0000` TXDATA.
  - Write pushes `wdata[7:0]` into the FIFO.
  - The push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and the sticky `ovf` flag sets.
  - Reads return 0.
- `0xFFFF0004` STATUS, read layout:
  - bit0 full, bit1 empty, bit2 `ovf`, bit3 `err`.
  - bits[8:4] FIFO count (0..FIFO_DEPTH); all other bits 0.
  - A write with `wdata[2]=1` clears `ovf`. All other bits are read-only.
  - If an overflow and a clear occur in the same cycle, set wins.
- `0xFFFF0008` CYCLE: read returns the cycle counter; writes are ignored.
- Any other MMIO offset reads 0; writes to it are ignored and do not set `err`.

TX FIFO and drain port:
- `tx_valid` = !empty; `tx_data` = head entry.
- A pop occurs when `tx_valid && tx_ready` at the edge.
- Push and pop in the same cycle: count unchanged, order preserved.
- Push into an empty FIFO: no same-cycle pop, because `tx_valid` was 0.
- Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Load latency 0: `rdata` is valid in the same cycle as `address`.
- A stored word is readable in the cycle after the store.
- A TXDATA store in cycle N:
  - `tx_valid` rises in cycle N+1 if the FIFO was empty.
  - STATUS.count reflects the push in cycle N+1.
- Reset (any cycle, including mid-drain) empties the FIFO and clears the pointers, count, `ovf`, `err` and the cycle counter.
- Reset values: `tx_valid`=0, `tx_data`=0, `err`=0. `rdata` follows the decode of `address`.
- Cycle counter:
  - Reads 0 in the first cycle after reset is released.
  - Increments by 1 every edge and wraps at 2^32.
  - Holds 0 while `reset` is high.

## Configuration
- `DMEM_CYCLE_COUNTER_EN` defined: the 32-bit cycle counter is built and CYCLE reads it.
- `DMEM_CYCLE_COUNTER_EN` undefined: no counter flops are built; CYCLE reads 0, and writes to it are still ignored without error.

## Structure
- Package `dmem_pkg` holds:
  - MMIO base `16'hFFFF` and the offsets TXDATA=0x0, STATUS=0x4, CYCLE=0x8.
  - STATUS bit positions (`ST_FULL`, `ST_EMPTY`, `ST_OVF`, `ST_ERR`, `ST_CNT_LSB`).
- One sub-module, `tx_byte_fifo`:
  - Parameterised by FIFO_DEPTH.
  - Ports: push/data in, pop, head out, full, empty, count.
  - Instantiated once.
- Address decode, RAM, STATUS/`ovf`/`err` logic and the counter stay in the top level.

## Test plan
- Store `0xDEADBEEF` to `0x00000010`, then load `0x00000010` next cycle → `rdata`=`0xDEADBEEF`; `err`=0.
- Store to `0x00000012` (misaligned) → next cycle `err`=1, STATUS bit3=1, word `0x10` unchanged; load `0x00000012` → `rdata`=0.
- Nine TXDATA stores of bytes `0x41..0x49` with `tx_ready`=0 and FIFO_DEPTH=8 → STATUS = full, count=8, `ovf`=1; drain gives `0x41..0x48` in order; STATUS write `0x4` clears `ovf`.
- FIFO full with `tx_ready`=1 while storing `0x5A` to TXDATA → push accepted, count stays 8, no `ovf`, `0x5A` is drained last.
- Reset asserted mid-drain with 3 bytes queued → next cycle `tx_valid`=0, STATUS = empty, count=0, `err`=0.
- With `DMEM_CYCLE_COUNTER_EN`: CYCLE reads 0 in the first cycle after reset release and 5 five cycles later. Without the macro: CYCLE reads 0 throughout.
